// File: rtl/core_retire_pkg.sv
// Shared types for the dual-pipe retire unit: per-pipe result slots and pair-queue entries.
package core_retire_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned REG_X0   = 0;

  typedef struct packed {
    logic                we;
    logic [RegAddrW-1:0] rd;
    logic [DataW-1:0]    data;
  } retire_slot_t;

  typedef struct packed {
    logic         mem_older;
    logic         br_done;
    logic         mem_done;
    retire_slot_t br;
    retire_slot_t mem;
  } retire_entry_t;

  // A slot only reaches the register file if it writes and does not target x0.
  function automatic logic slot_writes(retire_slot_t s);
    return s.we && (s.rd != RegAddrW'(REG_X0));
  endfunction

endpackage

// File: rtl/retire_order_steer.sv
// Maps the retiring head entry onto RF ports 0 (older) and 1 (younger) with write suppression.
module retire_order_steer
  import core_retire_pkg::*;
(
  input  logic                retire_i,
  input  retire_entry_t       head_i,
  output logic [1:0]          rf_we_o,
  output logic [RegAddrW-1:0] rf_waddr_o [1:0],
  output logic [DataW-1:0]    rf_wdata_o [1:0]
);

  retire_slot_t old_s;
  retire_slot_t yng_s;
  logic         old_we;
  logic         yng_we;

  always_comb begin
    old_s  = head_i.mem_older ? head_i.mem : head_i.br;
    yng_s  = head_i.mem_older ? head_i.br  : head_i.mem;
    yng_we = retire_i && slot_writes(yng_s);
    // Same destination: the younger instruction's write is the architecturally visible one.
    old_we = retire_i && slot_writes(old_s) && !(yng_we && (old_s.rd == yng_s.rd));

    rf_we_o       = {yng_we, old_we};
    rf_waddr_o[0] = old_we ? old_s.rd   : '0;
    rf_wdata_o[0] = old_we ? old_s.data : '0;
    rf_waddr_o[1] = yng_we ? yng_s.rd   : '0;
    rf_wdata_o[1] = yng_we ? yng_s.data : '0;
  end

endmodule

// File: rtl/dual_pipe_retire_unit.sv
// In-order pair queue that collects Branch/Memory writebacks and retires each pair
// to the two RF write ports once both results are present.
module dual_pipe_retire_unit
  import core_retire_pkg::*;
#(
  parameter int unsigned WIDTH    = DataW,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned REG_ADDR = RegAddrW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       issue_valid,
  input  logic                       issue_mem_older,
  output logic                       issue_ready,
  input  logic                       br_wb_valid,
  input  logic                       br_wb_we,
  input  logic [REG_ADDR-1:0]        br_wb_rd,
  input  logic [WIDTH-1:0]           br_wb_data,
  input  logic                       mem_wb_valid,
  input  logic                       mem_wb_we,
  input  logic [REG_ADDR-1:0]        mem_wb_rd,
  input  logic [WIDTH-1:0]           mem_wb_data,
  output logic [1:0]                 rf_we,
  output logic [REG_ADDR-1:0]        rf_waddr [1:0],
  output logic [WIDTH-1:0]           rf_wdata [1:0],
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       protocol_err
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  retire_entry_t   entry_q [DEPTH];
  retire_entry_t   entry_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW-1:0] br_wptr_q, br_wptr_d;
  logic [PtrW-1:0] mem_wptr_q, mem_wptr_d;
  logic            err_q, err_d;

  logic [PtrW-1:0] occ;
  retire_entry_t   head_entry;
  logic            issue_fire;
  logic            retire_fire;
  logic            br_hit;
  logic            mem_hit;

  assign occ          = tail_q - head_q;
  assign occupancy    = occ;
  assign issue_ready  = (occ < PtrW'(DEPTH));
  assign protocol_err = err_q;
  assign head_entry   = entry_q[head_q[IdxW-1:0]];

  assign issue_fire  = issue_valid && issue_ready && !flush;
  assign retire_fire = (occ != '0) && head_entry.br_done && head_entry.mem_done && !flush;
  // A write pointer equal to tail points at a pair that has not been issued yet.
  assign br_hit      = br_wb_valid && (br_wptr_q != tail_q);
  assign mem_hit     = mem_wb_valid && (mem_wptr_q != tail_q);

  always_comb begin
    entry_d    = entry_q;
    head_d     = head_q;
    tail_d     = tail_q;
    br_wptr_d  = br_wptr_q;
    mem_wptr_d = mem_wptr_q;
    err_d      = err_q;

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_d[i].br_done  = 1'b0;
        entry_d[i].mem_done = 1'b0;
      end
      head_d     = '0;
      tail_d     = '0;
      br_wptr_d  = '0;
      mem_wptr_d = '0;
    end else begin
      if (issue_fire) begin
        entry_d[tail_q[IdxW-1:0]].mem_older = issue_mem_older;
        entry_d[tail_q[IdxW-1:0]].br_done   = 1'b0;
        entry_d[tail_q[IdxW-1:0]].mem_done  = 1'b0;
        tail_d = tail_q + PtrW'(1);
      end

      if (br_hit) begin
        entry_d[br_wptr_q[IdxW-1:0]].br.we   = br_wb_we;
        entry_d[br_wptr_q[IdxW-1:0]].br.rd   = br_wb_rd;
        entry_d[br_wptr_q[IdxW-1:0]].br.data = br_wb_data;
        entry_d[br_wptr_q[IdxW-1:0]].br_done = 1'b1;
        br_wptr_d = br_wptr_q + PtrW'(1);
      end else if (br_wb_valid) begin
        err_d = 1'b1;
      end

      if (mem_hit) begin
        entry_d[mem_wptr_q[IdxW-1:0]].mem.we   = mem_wb_we;
        entry_d[mem_wptr_q[IdxW-1:0]].mem.rd   = mem_wb_rd;
        entry_d[mem_wptr_q[IdxW-1:0]].mem.data = mem_wb_data;
        entry_d[mem_wptr_q[IdxW-1:0]].mem_done = 1'b1;
        mem_wptr_d = mem_wptr_q + PtrW'(1);
      end else if (mem_wb_valid) begin
        err_d = 1'b1;
      end

      if (retire_fire) begin
        head_d = head_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      br_wptr_q  <= '0;
      mem_wptr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      br_wptr_q  <= br_wptr_d;
      mem_wptr_q <= mem_wptr_d;
      err_q      <= err_d;
    end
  end

  retire_order_steer u_steer (
    .retire_i   (retire_fire),
    .head_i     (head_entry),
    .rf_we_o    (rf_we),
    .rf_waddr_o (rf_waddr),
    .rf_wdata_o (rf_wdata)
  );

endmodule

// File: tb/tb_dual_pipe_retire_unit.sv
// Randomized and directed bench for dual_pipe_retire_unit against a queue-based pair model.
module tb_dual_pipe_retire_unit;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int RA = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          issue_valid;
  logic          issue_mem_older;
  logic          issue_ready;
  logic          br_wb_valid;
  logic          br_wb_we;
  logic [RA-1:0] br_wb_rd;
  logic [W-1:0]  br_wb_data;
  logic          mem_wb_valid;
  logic          mem_wb_we;
  logic [RA-1:0] mem_wb_rd;
  logic [W-1:0]  mem_wb_data;
  logic [1:0]    rf_we;
  logic [RA-1:0] rf_waddr [1:0];
  logic [W-1:0]  rf_wdata [1:0];
  logic [2:0]    occupancy;
  logic          protocol_err;

  always #5 clk = ~clk;

  dual_pipe_retire_unit #(
    .WIDTH    (W),
    .DEPTH    (D),
    .REG_ADDR (RA)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .issue_valid     (issue_valid),
    .issue_mem_older (issue_mem_older),
    .issue_ready     (issue_ready),
    .br_wb_valid     (br_wb_valid),
    .br_wb_we        (br_wb_we),
    .br_wb_rd        (br_wb_rd),
    .br_wb_data      (br_wb_data),
    .mem_wb_valid    (mem_wb_valid),
    .mem_wb_we       (mem_wb_we),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_data     (mem_wb_data),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .occupancy       (occupancy),
    .protocol_err    (protocol_err)
  );

  // Model: in-order list of issued pairs; br_cnt/mem_cnt = how many of them already hold a result.
  typedef struct {
    bit          mem_older;
    bit          br_we;
    logic [4:0]  br_rd;
    logic [31:0] br_data;
    bit          mem_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
  } pair_t;

  pair_t mq[$];
  int    br_cnt;
  int    mem_cnt;
  bit    err_m;
  int    n_cmp;
  int    n_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    br_cnt  = 0;
    mem_cnt = 0;
    err_m   = 1'b0;
  endtask

  task automatic model_outputs(output logic [1:0] we, output logic [4:0] a0, output logic [4:0] a1,
                               output logic [31:0] d0, output logic [31:0] d1);
    bit          ow, yw;
    logic [4:0]  orr, yr;
    logic [31:0] od, yd;
    pair_t       p;
    we = 2'b00; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    if (mq.size() > 0 && br_cnt > 0 && mem_cnt > 0 && !flush) begin
      p = mq[0];
      if (p.mem_older) begin
        ow = p.mem_we; orr = p.mem_rd; od = p.mem_data;
        yw = p.br_we;  yr  = p.br_rd;  yd = p.br_data;
      end else begin
        ow = p.br_we;  orr = p.br_rd;  od = p.br_data;
        yw = p.mem_we; yr  = p.mem_rd; yd = p.mem_data;
      end
      ow = ow && (orr != 0);
      yw = yw && (yr != 0);
      if (ow && yw && orr == yr) ow = 1'b0;
      we = {yw, ow};
      if (ow) begin a0 = orr; d0 = od; end
      if (yw) begin a1 = yr;  d1 = yd; end
    end
  endtask

  task automatic compare_all();
    logic [1:0]  we;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    model_outputs(we, a0, a1, d0, d1);
    chk("rf_we", rf_we, we);
    chk("rf_waddr0", rf_waddr[0], a0);
    chk("rf_waddr1", rf_waddr[1], a1);
    chk("rf_wdata0", rf_wdata[0], d0);
    chk("rf_wdata1", rf_wdata[1], d1);
    chk("occupancy", occupancy, mq.size());
    chk("issue_ready", issue_ready, (mq.size() < D));
    chk("protocol_err", protocol_err, err_m);
  endtask

  task automatic model_update();
    int    sz;
    bit    ret;
    pair_t np;
    if (flush) begin
      mq.delete();
      br_cnt  = 0;
      mem_cnt = 0;
      return;
    end
    sz  = mq.size();
    ret = (sz > 0) && (br_cnt > 0) && (mem_cnt > 0);
    if (br_wb_valid) begin
      if (br_cnt < sz) begin
        mq[br_cnt].br_we   = br_wb_we;
        mq[br_cnt].br_rd   = br_wb_rd;
        mq[br_cnt].br_data = br_wb_data;
        br_cnt++;
      end else err_m = 1'b1;
    end
    if (mem_wb_valid) begin
      if (mem_cnt < sz) begin
        mq[mem_cnt].mem_we   = mem_wb_we;
        mq[mem_cnt].mem_rd   = mem_wb_rd;
        mq[mem_cnt].mem_data = mem_wb_data;
        mem_cnt++;
      end else err_m = 1'b1;
    end
    if (issue_valid && sz < D) begin
      np = '{default: '0};
      np.mem_older = issue_mem_older;
      mq.push_back(np);
    end
    if (ret) begin
      void'(mq.pop_front());
      br_cnt--;
      mem_cnt--;
    end
  endtask

  task automatic idle();
    flush = 0; issue_valid = 0; issue_mem_older = 0;
    br_wb_valid = 0; br_wb_we = 0; br_wb_rd = '0; br_wb_data = '0;
    mem_wb_valid = 0; mem_wb_we = 0; mem_wb_rd = '0; mem_wb_data = '0;
  endtask

  task automatic set_br(input bit we, input int rd, input logic [31:0] data);
    br_wb_valid = 1; br_wb_we = we; br_wb_rd = RA'(rd); br_wb_data = data;
  endtask

  task automatic set_mem(input bit we, input int rd, input logic [31:0] data);
    mem_wb_valid = 1; mem_wb_we = we; mem_wb_rd = RA'(rd); mem_wb_data = data;
  endtask

  // One cycle: inputs are already driven; compare at negedge, advance model, land at posedge+1.
  task automatic tick();
    @(negedge clk);
    compare_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit mem_older);
    idle();
    issue_valid = 1; issue_mem_older = mem_older;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset occupancy", occupancy, 0);
    chk("reset issue_ready", issue_ready, 1);
    chk("reset rf_we", rf_we, 0);
    chk("reset protocol_err", protocol_err, 0);
    rst = 1'b0;

    // Same-cycle results, Branch older.
    issue(1'b0);
    idle(); set_br(1, 5, 32'h11); set_mem(1, 6, 32'h22); tick();
    idle();
    chk("t1 rf_we", rf_we, 2'b11);
    chk("t1 waddr0", rf_waddr[0], 5);
    chk("t1 waddr1", rf_waddr[1], 6);
    chk("t1 wdata0", rf_wdata[0], 32'h11);
    chk("t1 wdata1", rf_wdata[1], 32'h22);
    chk("t1 occ before", occupancy, 1);
    tick();
    chk("t1 occ after", occupancy, 0);

    // Late load, same rd; younger Branch wins.
    issue(1'b1);
    idle(); set_br(1, 7, 32'hA); tick();
    idle();
    chk("t2 wait1 rf_we", rf_we, 0);
    tick();
    chk("t2 wait2 rf_we", rf_we, 0);
    tick();
    chk("t2 wait3 rf_we", rf_we, 0);
    set_mem(1, 7, 32'hB); tick();
    idle();
    chk("t2 rf_we", rf_we, 2'b10);
    chk("t2 waddr1", rf_waddr[1], 7);
    chk("t2 wdata1", rf_wdata[1], 32'hA);
    chk("t2 waddr0", rf_waddr[0], 0);
    tick();

    // Fill to DEPTH; no same-cycle credit while retiring from full.
    for (int i = 0; i < D; i++) issue(i[0]);
    chk("t3 full ready", issue_ready, 0);
    chk("t3 full occ", occupancy, 4);
    idle(); issue_valid = 1; set_br(1, 1, 32'h100); set_mem(1, 2, 32'h200); tick();
    idle(); issue_valid = 1;
    chk("t3 retire-full ready", issue_ready, 0);
    chk("t3 retire-full rf_we", rf_we, 2'b11);
    chk("t3 retire-full occ", occupancy, 4);
    tick();
    idle();
    chk("t3 after ready", issue_ready, 1);
    chk("t3 after occ", occupancy, 3);
    for (int i = 0; i < 3; i++) begin
      idle(); set_br(1, i + 3, $urandom); set_mem(1, i + 10, $urandom); tick();
    end
    idle();
    repeat (3) tick();
    chk("t3 drained occ", occupancy, 0);

    // Bubble plus x0 write: nothing written but the pair still retires.
    issue(1'b0);
    idle(); set_br(0, 9, 32'h99); set_mem(1, 0, 32'h5); tick();
    idle();
    chk("t5 rf_we", rf_we, 2'b00);
    chk("t5 occ before", occupancy, 1);
    tick();
    chk("t5 occ after", occupancy, 0);

    // Flush with a complete head pair; later stray result flags an error.
    issue(1'b0);
    issue(1'b0);
    idle(); set_br(1, 8, 32'h1); set_mem(1, 9, 32'h2); tick();
    idle();
    chk("t4 pre-flush rf_we", rf_we, 2'b11);
    flush = 1;
    #1;
    chk("t4 flush rf_we", rf_we, 2'b00);
    tick();
    idle();
    chk("t4 occ after flush", occupancy, 0);
    chk("t4 err before stray", protocol_err, 0);
    set_br(1, 8, 32'h3); tick();
    idle();
    chk("t4 err after stray", protocol_err, 1);
    tick();
    chk("t4 err sticky", protocol_err, 1);

    // Asynchronous reset with pending pairs.
    issue(1'b0);
    issue(1'b1);
    issue(1'b0);
    idle(); set_br(1, 3, 32'h33); set_mem(1, 4, 32'h44); tick();
    idle();
    chk("t6 pre-reset rf_we", rf_we, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("t6 rst occ", occupancy, 0);
    chk("t6 rst ready", issue_ready, 1);
    chk("t6 rst rf_we", rf_we, 0);
    chk("t6 rst waddr0", rf_waddr[0], 0);
    chk("t6 rst wdata1", rf_wdata[1], 0);
    chk("t6 rst err", protocol_err, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t6 post occ", occupancy, 0);

    // Randomized traffic; results mostly only for issued pairs, occasional stray.
    for (int c = 0; c < 600; c++) begin
      idle();
      flush           = ($urandom_range(0, 39) == 0);
      issue_valid     = $urandom_range(0, 1);
      issue_mem_older = $urandom_range(0, 1);
      if ((br_cnt < mq.size()) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 199) == 0))
        set_br($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom);
      if ((mem_cnt < mq.size()) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 199) == 0))
        set_mem($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom);
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_pipe_retire_unit.md
Name: dual_pipe_retire_unit

Overview:
- Sits at the writeback end of the dual-issue core and receives the instruction pairs that the issue stage splits across the Branch and Memory pipelines.
- Records each issued pair's program order in a small in-order queue. It then collects each pipeline's writeback result.
- A pair retires only when both of its results are present. Retirement drives the two register-file write ports in program order, older instruction first.
- Absorbs Memory-pipeline latency skew, such as a load that completes several cycles after its Branch-pipeline partner.

Parameters:
- WIDTH, 32, data width
- DEPTH, 4, pair-queue entries (power of two, ≥2)
- REG_ADDR, 5, register index width

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  mispredict flush; discards all in-flight pairs
- issue_valid  in  1  a pair is issued this cycle
- issue_mem_older  in  1  1 = Memory-pipe instruction is older in the pair; 0 = Branch-pipe instruction is older
- issue_ready  out  1  queue can accept a pair
- br_wb_valid  in  1  Branch-pipe writeback slot valid (bubbles included)
- br_wb_we  in  1  Branch-pipe result writes the RF
- br_wb_rd  in  REG_ADDR  Branch-pipe destination register
- br_wb_data  in  WIDTH  Branch-pipe result
- mem_wb_valid / mem_wb_we / mem_wb_rd / mem_wb_data  in  1/1/REG_ADDR/WIDTH  same four signals for the Memory pipe
- rf_we  out  2  write enables; [0] = older instruction, [1] = younger
- rf_waddr  out  2×REG_ADDR  write addresses, unpacked [1:0]
- rf_wdata  out  2×WIDTH  write data, unpacked [1:0]
- occupancy  out  $clog2(DEPTH)+1  pairs currently held
- protocol_err  out  1  sticky error flag

Behaviour:
- Every issued pair occupies both pipelines. An unused slot travels as a bubble with wb_valid=1 and wb_we=0. Each pipe's k-th wb_valid therefore belongs to the k-th issued pair.
- State:
  - per entry: mem_older, br_done, mem_done, and the captured we/rd/data for each pipe
  - pointers: head, tail, br_wptr, mem_wptr (each $clog2(DEPTH)+1 bits, wrap bit included)
- Issue: when issue_valid && issue_ready, entry[tail] is written with mem_older, both done flags are cleared, and tail increments on the clock edge.
- issue_ready = (occupancy < DEPTH). When full it stays 0, even in a cycle where a retire happens; there is no same-cycle credit.
- Result capture: br_wb_valid writes entry[br_wptr] and sets br_done, then br_wptr increments. The Memory pipe behaves identically using mem_wptr. Both pipes may capture in the same cycle, including into the same entry.
- Result for a not-yet-issued pair: when wptr==tail, the result is dropped and protocol_err is set.
- An issue and a result for that same new entry in one cycle counts as a protocol error, handled as above.
- Retire: when occupancy≠0 && entry[head].br_done && entry[head].mem_done:
  - rf outputs are driven combinationally from entry[head] and head increments on the edge.
  - Latency: the last result valid in cycle t gives rf_we in cycle t+1.
  - At most one pair retires per cycle.
- Port steering:
  - mem_older=1: port0 = Memory result, port1 = Branch result.
  - mem_older=0: the reverse.
- Write-enable rules:
  - rd==0 forces that port's we to 0.
  - If both ports have we=1 and equal rd, rf_we[0] is forced to 0 so the younger instruction wins.
- rf_waddr and rf_wdata equal 0 whenever the corresponding rf_we is 0.
- occupancy = tail − head, and is updated by simultaneous issue and retire in the same cycle.
- Flush (synchronous, highest priority):
  - head, tail, br_wptr, mem_wptr and all done flags clear at the next edge.
  - issue, results and retire in the flush cycle are discarded; rf_we is forced to 0 during the flush cycle.
  - protocol_err is not cleared.
- Reset (asynchronous, may assert mid-operation): all pointers, flags and protocol_err become 0. Output values while reset is asserted:
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - occupancy=0
  - issue_ready=1
- Pointer wrap uses the extra MSB: full when tail−head==DEPTH, empty when equal.

Decomposition:
- Shared package core_retire_pkg:
  - typedef retire_slot_t {we, rd, data}
  - typedef retire_entry_t {mem_older, br_done, mem_done, retire_slot_t br, retire_slot_t mem}
  - localparam REG_X0 = 0
- One sub-module, retire_order_steer: combinational mapping of the head entry to ports 0/1, covering x0 suppression and same-rd suppression.

Test Plan:
- Issue pair (mem_older=0); Branch result x5=0x11 and Memory result x6=0x22 in the same cycle → next cycle rf_we=2'b11, waddr={6,5}, wdata={0x22,0x11}; occupancy 1→0.
- Issue pair (mem_older=1); Branch result x7=0xA arrives, Memory result x7=0xB arrives 3 cycles later → no rf_we for 3 cycles, then rf_we=2'b10 with waddr[1]=7, wdata[1]=0xA (younger Branch instruction wins).
- Issue DEPTH=4 pairs with no results → issue_ready=0 and occupancy=4; a 5th issue_valid is ignored. Complete the head pair → retire, then issue_ready=1 on the following cycle.
- Issue 2 pairs and complete pair 0 → flush asserted → rf_we=0 in the flush cycle, occupancy=0 afterwards; later results for the flushed pairs set protocol_err=1.
- Bubble slot with we=0, plus a write to rd=x0 with we=1 → rf_we=2'b00, and the pair still retires (occupancy decrements).
- Assert rst mid-way with 3 pairs pending → outputs go to reset values immediately, occupancy=0, and normal operation resumes after deassert.
